// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall vector constants and controller state type for pipe_stall_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  localparam logic [4:0] STALL_NONE    = 5'b00000;
  localparam logic [4:0] STALL_LOADUSE = 5'b00011;
  localparam logic [4:0] STALL_MC      = 5'b00111;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hold_cnt.sv
// rtl/pipe_stall_ctrl_hold_cnt.sv - loadable down-counter with last flag sequencing multi-cycle EX holds
module pipe_hold_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decrement is gated at zero so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller; PIPE_STALL_CTRL_PERF_EN adds stall/flush perf counters
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall_req_i,
  input  logic             ex_mc_start_i,
  input  logic [CNT_W-1:0] ex_mc_cycles_i,
  input  logic             flush_req_i,
  input  logic [PC_W-1:0]  flush_pc_i,
  output logic [4:0]       stall_o,
  output logic             flush_o,
  output logic [PC_W-1:0]  new_pc_o,
  output logic             ex_busy_o,
  output logic             ex_mc_done_o,
  output logic             ex_mc_abort_o
`ifdef PIPE_STALL_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt_o,
  output logic [31:0]      perf_flush_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_load_val;

  pipe_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    stall_o       = STALL_NONE;
    flush_o       = 1'b0;
    new_pc_o      = '0;
    ex_busy_o     = 1'b0;
    ex_mc_done_o  = 1'b0;
    ex_mc_abort_o = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_load_val  = '0;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          flush_o  = 1'b1;
          new_pc_o = flush_pc_i;
        end else if (done_q) begin
          ex_mc_done_o = 1'b1;
        end else if (ex_mc_start_i) begin
          // N=2 needs one stall cycle and no hold state; N<2 completes in place.
          if (ex_mc_cycles_i >= CNT_W'(2)) begin
            stall_o = STALL_MC;
            if (ex_mc_cycles_i == CNT_W'(2)) begin
              done_d = 1'b1;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = ex_mc_cycles_i - CNT_W'(2);
              state_d      = MC_HOLD;
            end
          end else begin
            ex_mc_done_o = 1'b1;
          end
        end else if (id_stall_req_i) begin
          stall_o = STALL_LOADUSE;
        end
      end
      MC_HOLD: begin
        ex_busy_o = 1'b1;
        if (flush_req_i) begin
          flush_o       = 1'b1;
          new_pc_o      = flush_pc_i;
          ex_mc_abort_o = 1'b1;
          cnt_clr       = 1'b1;
          state_d       = IDLE;
        end else begin
          stall_o = STALL_MC;
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
    if (rst) begin
      stall_o       = STALL_NONE;
      flush_o       = 1'b0;
      new_pc_o      = '0;
      ex_busy_o     = 1'b0;
      ex_mc_done_o  = 1'b0;
      ex_mc_abort_o = 1'b0;
    end
  end

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((stall_o != STALL_NONE) && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush_o && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall_req_i;
  logic        ex_mc_start_i;
  logic [5:0]  ex_mc_cycles_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        ex_busy_o;
  logic        ex_mc_done_o;
  logic        ex_mc_abort_o;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(6), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_stall_req_i (id_stall_req_i),
    .ex_mc_start_i  (ex_mc_start_i),
    .ex_mc_cycles_i (ex_mc_cycles_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .ex_busy_o      (ex_busy_o),
    .ex_mc_done_o   (ex_mc_done_o),
    .ex_mc_abort_o  (ex_mc_abort_o)
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
  );

  task automatic drive(input logic r, input logic id, input logic st, input logic [5:0] n,
                       input logic fl, input logic [31:0] pc);
    rst            = r;
    id_stall_req_i = id;
    ex_mc_start_i  = st;
    ex_mc_cycles_i = n;
    flush_req_i    = fl;
    flush_pc_i     = pc;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] es, input logic ef, input logic [31:0] ep,
                     input logic ed, input logic ea);
    checks++;
    assert (stall_o === es) else begin
      errors++; $error("FAIL %s stall_o: got %b expected %b", tag, stall_o, es);
    end
    checks++;
    assert (flush_o === ef) else begin
      errors++; $error("FAIL %s flush_o: got %b expected %b", tag, flush_o, ef);
    end
    checks++;
    assert (new_pc_o === ep) else begin
      errors++; $error("FAIL %s new_pc_o: got %h expected %h", tag, new_pc_o, ep);
    end
    checks++;
    assert (ex_mc_done_o === ed) else begin
      errors++; $error("FAIL %s ex_mc_done_o: got %b expected %b", tag, ex_mc_done_o, ed);
    end
    checks++;
    assert (ex_mc_abort_o === ea) else begin
      errors++; $error("FAIL %s ex_mc_abort_o: got %b expected %b", tag, ex_mc_abort_o, ea);
    end
  endtask

  task automatic chk_busy(input string tag, input logic eb);
    checks++;
    assert (ex_busy_o === eb) else begin
      errors++; $error("FAIL %s ex_busy_o: got %b expected %b", tag, ex_busy_o, eb);
    end
  endtask

  initial begin
    // Reset with every request high.
    drive(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
    next_cycle(); drive(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
    chk("rst0", 5'b00000, 0, 32'h0, 0, 0); chk_busy("rst0", 0);
    next_cycle(); drive(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
    chk("rst1", 5'b00000, 0, 32'h0, 0, 0); chk_busy("rst1", 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("idle", 5'b00000, 0, 32'h0, 0, 0); chk_busy("idle", 0);

    // Load-use.
    next_cycle(); drive(0, 1, 0, 6'd0, 0, 32'h0);
    chk("lu", 5'b00011, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("lu_end", 5'b00000, 0, 32'h0, 0, 0);

    // N=5: stall t..t+3, busy t+1..t+3, done t+4.
    next_cycle(); drive(0, 0, 1, 6'd5, 0, 32'h0);
    chk("n5_t0", 5'b00111, 0, 32'h0, 0, 0); chk_busy("n5_t0", 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
      chk("n5_hold", 5'b00111, 0, 32'h0, 0, 0); chk_busy("n5_hold", 1);
    end
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n5_done", 5'b00000, 0, 32'h0, 1, 0); chk_busy("n5_done", 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n5_after", 5'b00000, 0, 32'h0, 0, 0);

    // N=2.
    next_cycle(); drive(0, 0, 1, 6'd2, 0, 32'h0);
    chk("n2_t0", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n2_done", 5'b00000, 0, 32'h0, 1, 0); chk_busy("n2_done", 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n2_after", 5'b00000, 0, 32'h0, 0, 0);

    // N=1 and N=0: done same cycle, no stall.
    next_cycle(); drive(0, 0, 1, 6'd1, 0, 32'h0);
    chk("n1", 5'b00000, 0, 32'h0, 1, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n1_after", 5'b00000, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 1, 6'd0, 0, 32'h0);
    chk("n0", 5'b00000, 0, 32'h0, 1, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("n0_after", 5'b00000, 0, 32'h0, 0, 0);

    // N=8 flushed at t+3.
    next_cycle(); drive(0, 0, 1, 6'd8, 0, 32'h0);
    chk("fl_t0", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("fl_t1", 5'b00111, 0, 32'h0, 0, 0); chk_busy("fl_t1", 1);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("fl_t2", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 1, 32'h0000_0100);
    chk("fl_t3", 5'b00000, 1, 32'h0000_0100, 0, 1);
    for (int i = 4; i <= 9; i++) begin
      next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
      chk("fl_after", 5'b00000, 0, 32'h0, 0, 0); chk_busy("fl_after", 0);
    end

    // Flush, start and load-use together in IDLE.
    next_cycle(); drive(0, 1, 1, 6'd4, 1, 32'h0000_0200);
    chk("sim", 5'b00000, 1, 32'h0000_0200, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("sim_after", 5'b00000, 0, 32'h0, 0, 0); chk_busy("sim_after", 0);

    // Load-use during MC_HOLD is masked.
    next_cycle(); drive(0, 0, 1, 6'd4, 0, 32'h0);
    chk("mh_t0", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 1, 0, 6'd0, 0, 32'h0);
    chk("mh_lu1", 5'b00111, 0, 32'h0, 0, 0); chk_busy("mh_lu1", 1);
    next_cycle(); drive(0, 1, 0, 6'd0, 0, 32'h0);
    chk("mh_lu2", 5'b00111, 0, 32'h0, 0, 0); chk_busy("mh_lu2", 1);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("mh_done", 5'b00000, 0, 32'h0, 1, 0);

    // Flush in the done cycle of an N=2 op.
    next_cycle(); drive(0, 0, 1, 6'd2, 0, 32'h0);
    chk("fd_t0", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 1, 32'h0000_0300);
    chk("fd_t1", 5'b00000, 1, 32'h0000_0300, 0, 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("fd_after", 5'b00000, 0, 32'h0, 0, 0);

    // Reset mid-MC_HOLD.
    next_cycle(); drive(0, 0, 1, 6'd8, 0, 32'h0);
    chk("rh_t0", 5'b00111, 0, 32'h0, 0, 0);
    next_cycle(); drive(1, 0, 0, 6'd0, 0, 32'h0);
    chk("rh_rst", 5'b00000, 0, 32'h0, 0, 0); chk_busy("rh_rst", 0);
    next_cycle(); drive(0, 0, 0, 6'd0, 0, 32'h0);
    chk("rh_after", 5'b00000, 0, 32'h0, 0, 0); chk_busy("rh_after", 0);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      chk("rh_quiet", 5'b00000, 0, 32'h0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It collects hazard requests from ID (load-use), from EX (multi-cycle ALU ops such as mult/div) and from the branch/exception logic. It drives per-stage hold signals to the PC register and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and drives a global flush with a redirect PC. It owns a small FSM and a hold counter that sequence multi-cycle EX operations.

Parameters:
CNT_W, 6, width of multi-cycle length input and internal hold counter (max op length 2^CNT_W-1 cycles)
PC_W, 32, width of redirect PC

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
id_stall_req_i  input  1  load-use hazard from ID; level, combinational same-cycle
ex_mc_start_i  input  1  EX begins a multi-cycle op this cycle; 1-cycle pulse
ex_mc_cycles_i  input  CNT_W  total EX occupancy N of the op; sampled with ex_mc_start_i
flush_req_i  input  1  branch mispredict/exception redirect request; 1-cycle pulse
flush_pc_i  input  PC_W  redirect target; valid with flush_req_i
stall_o  output  5  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
flush_o  output  1  clear IF/ID, ID/EX, EX/MEM contents to reset values at next edge
new_pc_o  output  PC_W  redirect PC; valid when flush_o=1, else 0
ex_busy_o  output  1  multi-cycle op in progress (MC_HOLD state)
ex_mc_done_o  output  1  result-valid cycle of multi-cycle op; pipeline advances at end of this cycle
ex_mc_abort_o  output  1  multi-cycle op killed by flush

Behaviour:
- Bubble rule: if stage i is held and stage i+1 is not, the downstream register loads reset/NOP values. Pipeline registers implement this; the controller only drives stall_o.
- stall_o, flush_o, new_pc_o, ex_mc_done_o and ex_mc_abort_o are combinational from state and inputs (zero latency). State and counter are registered.
- States: IDLE, MC_HOLD. Counter cnt, CNT_W bits.
- Reset: state=IDLE, cnt=0. During rst=1 all outputs are 0 regardless of inputs.
- Priority in IDLE: flush > multi-cycle start > id stall.
  - flush_req_i=1: flush_o=1, new_pc_o=flush_pc_i, stall_o=0. Stay IDLE. A coincident start or id stall is ignored.
  - ex_mc_start_i=1 with N>=2: stall_o=5'b00111 (bubble into EX/MEM). If N=2: cnt stays 0, stay IDLE, and ex_mc_done_o=1 next cycle. If N>2: cnt<=N-2, go MC_HOLD.
  - ex_mc_start_i=1 with N in {0,1}: treated as a single-cycle op. stall_o=0, ex_mc_done_o=1 same cycle.
  - id_stall_req_i=1 only: stall_o=5'b00011 (bubble into ID/EX).
  - otherwise stall_o=0.
- MC_HOLD:
  - stall_o=5'b00111 and ex_busy_o=1. id_stall_req_i and ex_mc_start_i are ignored.
  - cnt<=cnt-1 each cycle. When cnt==1, next state is IDLE with a done flag registered.
  - The first IDLE cycle after MC_HOLD (or after an N=2 start) asserts ex_mc_done_o=1 and stall_o=0, unless flush.
  - Total stall cycles for an N-cycle op = N-1.
- Flush in MC_HOLD: flush_o=1, new_pc_o=flush_pc_i, stall_o=0, ex_mc_abort_o=1. cnt<=0, next state IDLE, no ex_mc_done_o.
- Flush in the done cycle: flush wins, done suppressed, abort=0 (result discarded by the flush).
- rst mid-MC_HOLD: immediate return to IDLE at the edge; no done or abort pulse.
- Counter never wraps: loaded only from IDLE, decrements only while cnt>=1.

Optional Feature:
PIPE_STALL_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt_o[31:0] (cycles with stall_o!=0) and perf_flush_cnt_o[31:0] (cycles with flush_o=1). Both are saturating at 32'hFFFFFFFF and cleared by rst.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - stall bit index constants: STALL_PC=0, STALL_IFID=1, STALL_IDEX=2, STALL_EXMEM=3, STALL_MEMWB=4
  - stall vector constants: STALL_NONE=5'b00000, STALL_LOADUSE=5'b00011, STALL_MC=5'b00111
  - state typedef: IDLE, MC_HOLD
- One sub-module is natural: pipe_hold_cnt, the loadable CNT_W down-counter with a last flag.

Test Plan:
- Reset: assert rst 2 cycles with all requests high -> all outputs 0. After release with no requests, stall_o=0 and state IDLE.
- Load-use: id_stall_req_i=1 for 1 cycle -> stall_o=5'b00011 that cycle only. Next cycle 0.
- Multi-cycle N=5: pulse start at cycle t -> stall_o=5'b00111 on t..t+3, ex_busy_o=1 on t+1..t+3, ex_mc_done_o=1 and stall_o=0 on t+4.
- Short ops: N=2 -> stall only at t, done at t+1. N=1 -> no stall, done at t. N=0 -> same as N=1.
- Flush mid-op: N=8, flush_req_i at t+3 with flush_pc_i=32'h0000_0100 -> flush_o=1, new_pc_o=32'h100, ex_mc_abort_o=1, stall_o=0 at t+3. IDLE at t+4, no done ever.
- Simultaneous: flush_req_i, ex_mc_start_i (N=4) and id_stall_req_i all high in IDLE -> flush only, stall_o=0, no MC_HOLD entry. Also: id_stall_req_i during MC_HOLD -> stall_o stays 5'b00111.
